encoder_rr_n: RTL

Parametrised, registered N-to-log2(N) encoder with a valid/ready handshake on both sides. It replaces fixed 32-to-5 decode-select encoding in the datapath (register-select and bus-source select). It adds four things the fixed encoder lacks:
- defined handling of multi-hot inputs via priority resolution,
- an explicit "no request" flag,
- one-cycle registered output with backpressure,
- optional round-robin priority.

---
 rtl/encoder_rr_n.sv | 114 +++++++++++
 1 files changed

// File: rtl/encoder_rr_n.sv
// Registered N-to-log2(N) priority encoder with valid/ready on both sides.
// Round-robin priority is enabled by defining ENCODER_RR_ROUND_ROBIN_EN; otherwise lowest index wins.
module encoder_rr_n #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned IDX_W       = $clog2(WIDTH),
  parameter int unsigned DEFAULT_IDX = WIDTH - 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] req,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [WIDTH-1:0] out_onehot,
  output logic             out_none,
  output logic             out_multi,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             accept;
  logic [IDX_W-1:0] base;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic             multi;
  int unsigned      scan_pos;

  logic             out_valid_d,  out_valid_q;
  logic [IDX_W-1:0] out_idx_d,    out_idx_q;
  logic [WIDTH-1:0] out_onehot_d, out_onehot_q;
  logic             out_none_d,   out_none_q;
  logic             out_multi_d,  out_multi_q;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign multi    = |(req & (req - WIDTH'(1)));

  // First set bit at or above base, wrapping at WIDTH-1 (not at 2^IDX_W).
  always_comb begin : win_search
    scan_pos  = 0;
    win_found = 1'b0;
    win_idx   = IDX_W'(DEFAULT_IDX);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      scan_pos = 32'(base) + i;
      if (scan_pos >= WIDTH) scan_pos = scan_pos - WIDTH;
      if (!win_found && req[IDX_W'(scan_pos)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(scan_pos);
      end
    end
  end

`ifdef ENCODER_RR_ROUND_ROBIN_EN
  logic [IDX_W-1:0] base_d, base_q;

  // Advance past the winner so persistent requesters rotate.
  always_comb begin : base_next
    base_d = base_q;
    if (accept && win_found) begin
      base_d = (32'(win_idx) == WIDTH - 1) ? '0 : win_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin : base_reg
    if (!clr_n) base_q <= '0;
    else        base_q <= base_d;
  end

  assign base = base_q;
`else
  assign base = '0;
`endif

  // Output register load on accept, drain on consume, hold on stall.
  always_comb begin : out_next
    out_valid_d  = out_valid_q;
    out_idx_d    = out_idx_q;
    out_onehot_d = out_onehot_q;
    out_none_d   = out_none_q;
    out_multi_d  = out_multi_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_idx_d    = win_idx;
      out_onehot_d = win_found ? (WIDTH'(1) << win_idx) : '0;
      out_none_d   = !win_found;
      out_multi_d  = multi;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin : out_reg
    if (!clr_n) begin
      out_valid_q  <= 1'b0;
      out_idx_q    <= IDX_W'(DEFAULT_IDX);
      out_onehot_q <= '0;
      out_none_q   <= 1'b0;
      out_multi_q  <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      out_onehot_q <= out_onehot_d;
      out_none_q   <= out_none_d;
      out_multi_q  <= out_multi_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign out_onehot = out_onehot_q;
  assign out_none   = out_none_q;
  assign out_multi  = out_multi_q;

endmodule
